// File: rtl/gestor_digitos_vga_pkg.sv
// Shared constants for the VGA two-digit BCD field overlay: glyph codes and screen layout.
// Latency: none (constants, types and a helper function only).
// Backpressure: none.
//
// Contents: the ten digit glyph codes, the blank code, the per-field (row, tens column)
// table indexed 1..15, and the pipeline position record used between stages.
package gestor_digitos_vga_pkg;

    localparam int MAX_CAMPOS = 15;

    // Character ROM code for anything that is not a displayable digit.
    localparam logic [7:0] CODIGO_BLANCO = 8'h00;

    // Character ROM codes for digits 0..9. The ROM does not store the digits in order.
    localparam logic [7:0] CODIGO_DIGITO [0:9] = '{
        8'h0D, 8'h19, 8'h0E, 8'h18, 8'h0F,
        8'h17, 8'h10, 8'h16, 8'h11, 8'h15
    };

    // Screen placement of one field: character row and the column of its tens digit.
    // The units digit always sits one column to the right.
    typedef struct packed {
        logic [5:0] fila;
        logic [6:0] col;
    } ubicacion_t;

    // Entries 10..15 are a spare row for builds with more than nine fields.
    localparam ubicacion_t UBICACION [1:MAX_CAMPOS] = '{
        '{6'd13, 7'd10}, '{6'd13, 7'd13}, '{6'd13, 7'd16},
        '{6'd13, 7'd73}, '{6'd13, 7'd76}, '{6'd13, 7'd79},
        '{6'd15, 7'd37}, '{6'd15, 7'd43}, '{6'd15, 7'd52},
        '{6'd17, 7'd10}, '{6'd17, 7'd13}, '{6'd17, 7'd16},
        '{6'd17, 7'd19}, '{6'd17, 7'd22}, '{6'd17, 7'd25}
    };

    // Beam position captured by the first pipeline stage.
    typedef struct packed {
        logic [5:0] fila;
        logic [6:0] col;
        logic [2:0] linea;
    } posicion_t;

    function automatic logic es_bcd(input logic [3:0] nibble);
        return nibble <= 4'd9;
    endfunction

endpackage

// File: rtl/gestor_digitos_vga_if.sv
// Bus between the host/scan logic and the digit manager: write port, edit select, beam position, ROM address.
// Latency: none (wires only); the manager answers a beam position two clocks later.
// Backpressure: none; writes are fire-and-forget strobes and the scan never stalls.
//
// Signals: RD (active-low write strobe), DIR_DATO (BCD pair), POSICION (target field),
// EDIT_CAMPO (field being edited, 0 = none), Qh/Qv (beam column/row),
// DIR_MEM/DIR_VALIDA (character ROM address and digit-present flag).
interface gestor_digitos_vga_if;

    logic        RD;
    logic [7:0]  DIR_DATO;
    logic [3:0]  POSICION;
    logic [3:0]  EDIT_CAMPO;
    logic [6:0]  Qh;
    logic [9:0]  Qv;
    logic [11:0] DIR_MEM;
    logic        DIR_VALIDA;

    // Host / video timing side.
    modport master (
        output RD, DIR_DATO, POSICION, EDIT_CAMPO, Qh, Qv,
        input  DIR_MEM, DIR_VALIDA
    );

    // Digit manager side.
    modport slave (
        input  RD, DIR_DATO, POSICION, EDIT_CAMPO, Qh, Qv,
        output DIR_MEM, DIR_VALIDA
    );

endinterface

// File: rtl/gestor_digitos_vga_bcd_a_rom.sv
// Maps one BCD nibble to its character ROM glyph code; non-BCD values give the blank code.
// Latency: combinational.
// Backpressure: none.
//
// Ports: nibble (4-bit digit in), codigo (8-bit glyph code out).
module bcd_a_rom
    import gestor_digitos_vga_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] codigo
);

    always_comb begin
        codigo = CODIGO_BLANCO;
        for (int d = 0; d < 10; d++) begin
            if (nibble == 4'(d)) begin
                codigo = CODIGO_DIGITO[d];
            end
        end
    end

endmodule

// File: rtl/gestor_digitos_vga.sv
// Holds N two-digit BCD fields and turns the beam position into a character ROM address for them.
// Latency: 2 clocks from Qh/Qv to DIR_MEM/DIR_VALIDA; writes are visible to the next stage-2 decode.
// Backpressure: none; a write is taken on every edge with RD low, the scan pipeline never stalls.
//
// Ports: reloj (clock), resetM (async active-high reset), bus (slave modport of
// gestor_digitos_vga_if carrying the write port, edit select, beam position and ROM address).
module gestor_digitos_vga
    import gestor_digitos_vga_pkg::*;
#(
    parameter int N_CAMPOS       = 9,
    parameter int ANCHO_PARPADEO = 24
) (
    input  logic                 reloj,
    input  logic                 resetM,
    gestor_digitos_vga_if.slave  bus
);

    // Field storage, indexed by field number as seen on POSICION/EDIT_CAMPO.
    logic [3:0] decenas  [1:N_CAMPOS];
    logic [3:0] unidades [1:N_CAMPOS];

    logic [ANCHO_PARPADEO-1:0] parpadeo;

    posicion_t  etapa1;

    logic [3:0] campo_sel;     // field under the stage-1 position, 0 when none
    logic [3:0] nibble_sel;    // digit of that field under the beam
    logic [7:0] codigo;
    logic       oculto;
    logic       mostrar;

    logic [11:0] dir_mem_q;
    logic        dir_valida_q;

    // Qv[3] is the upper half of a 16-line character cell; the glyphs are only 8 lines tall.
    logic unused_qv3;
    assign unused_qv3 = bus.Qv[3];

    // ------------------------------------------------------------------
    // Field registers. Comparing POSICION against every legal index means
    // index 0 and indices past N_CAMPOS match nothing and are dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            for (int i = 1; i <= N_CAMPOS; i++) begin
                decenas[i]  <= 4'hF;
                unidades[i] <= 4'hF;
            end
        end else if (!bus.RD) begin
            for (int i = 1; i <= N_CAMPOS; i++) begin
                if (bus.POSICION == 4'(i)) begin
                    decenas[i]  <= bus.DIR_DATO[7:4];
                    unidades[i] <= bus.DIR_DATO[3:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Free-running blink counter; its MSB gives a 50% duty blink.
    // ------------------------------------------------------------------
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            parpadeo <= '0;
        end else begin
            parpadeo <= parpadeo + ANCHO_PARPADEO'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 decode: find which field digit (if any) sits under the
    // registered beam position. The field registers are read before this
    // edge's write lands, so a same-cycle write shows up one cycle later.
    // ------------------------------------------------------------------
    always_comb begin
        campo_sel  = 4'd0;
        nibble_sel = 4'hF;
        for (int i = 1; i <= N_CAMPOS; i++) begin
            if (etapa1.fila == UBICACION[i].fila) begin
                if (etapa1.col == UBICACION[i].col) begin
                    campo_sel  = 4'(i);
                    nibble_sel = decenas[i];
                end else if (etapa1.col == UBICACION[i].col + 7'd1) begin
                    campo_sel  = 4'(i);
                    nibble_sel = unidades[i];
                end
            end
        end
    end

    // campo_sel never exceeds N_CAMPOS, so an out-of-range EDIT_CAMPO simply never matches.
    assign oculto  = parpadeo[ANCHO_PARPADEO-1] && (campo_sel != 4'd0)
                     && (campo_sel == bus.EDIT_CAMPO);
    assign mostrar = (campo_sel != 4'd0) && es_bcd(nibble_sel) && !oculto;

    bcd_a_rom u_bcd_a_rom (
        .nibble (nibble_sel),
        .codigo (codigo)
    );

    // ------------------------------------------------------------------
    // Pipeline registers. Anything not shown (no field, non-BCD nibble,
    // blink-off phase) drives a zero address rather than {blank, line}.
    // ------------------------------------------------------------------
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            etapa1       <= '0;
            dir_mem_q    <= 12'h000;
            dir_valida_q <= 1'b0;
        end else begin
            etapa1       <= '{fila: bus.Qv[9:4], col: bus.Qh, linea: bus.Qv[2:0]};
            dir_valida_q <= mostrar;
            dir_mem_q    <= mostrar ? {codigo, 1'b0, etapa1.linea} : 12'h000;
        end
    end

    assign bus.DIR_MEM    = dir_mem_q;
    assign bus.DIR_VALIDA = dir_valida_q;

endmodule

// File: tb/tb_gestor_digitos_vga.sv
// Bench for gestor_digitos_vga: directed scenarios with literal expectations plus a randomized scan.
// A field-level model predicts every output cycle; a negedge process compares DUT against it.
// Built with a 4-bit blink counter so the blink period is 16 cycles.
module tb_gestor_digitos_vga;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gestor_digitos_vga_if bus ();

    gestor_digitos_vga #(
        .N_CAMPOS       (9),
        .ANCHO_PARPADEO (4)
    ) dut (
        .reloj  (clk),
        .resetM (rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    int GLIFO  [0:9] = '{'h0D, 'h19, 'h0E, 'h18, 'h0F, 'h17, 'h10, 'h16, 'h11, 'h15};
    int FILA_M [1:9] = '{13, 13, 13, 13, 13, 13, 15, 15, 15};
    int COL_M  [1:9] = '{10, 13, 16, 73, 76, 79, 37, 43, 52};

    int dec_m [1:9];
    int uni_m [1:9];
    int ciclo;                      // edges seen since reset released
    int p_fila, p_col, p_lin;       // beam position seen one edge ago
    logic [11:0] exp_mem = '0;
    logic        exp_val = 1'b0;

    // What the screen must show at a position, given the stored fields and blink phase.
    function automatic logic [11:0] modelo_salida(input int fila, input int col, input int lin,
                                                  input int edit, input int cic);
        for (int f = 1; f <= 9; f++) begin
            if (fila == FILA_M[f] && (col == COL_M[f] || col == COL_M[f] + 1)) begin
                int nib;
                nib = (col == COL_M[f]) ? dec_m[f] : uni_m[f];
                if (edit == f && (cic % 16) >= 8) return 12'h000;
                if (nib > 9) return 12'h000;
                return {8'(GLIFO[nib]), 1'b0, 3'(lin)};
            end
        end
        return 12'h000;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 1; f <= 9; f++) begin
                dec_m[f] = 15;
                uni_m[f] = 15;
            end
            ciclo   = 0;
            p_fila  = 0;
            p_col   = 0;
            p_lin   = 0;
            exp_mem = 12'h000;
            exp_val = 1'b0;
        end else begin
            exp_mem = modelo_salida(p_fila, p_col, p_lin, int'(bus.EDIT_CAMPO), ciclo);
            exp_val = (exp_mem != 12'h000);
            if (!bus.RD && bus.POSICION >= 4'd1 && bus.POSICION <= 4'd9) begin
                dec_m[bus.POSICION] = int'(bus.DIR_DATO[7:4]);
                uni_m[bus.POSICION] = int'(bus.DIR_DATO[3:0]);
            end
            ciclo  = ciclo + 1;
            p_fila = int'(bus.Qv[9:4]);
            p_col  = int'(bus.Qh);
            p_lin  = int'(bus.Qv[2:0]);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        checks++;
        if (bus.DIR_MEM !== exp_mem || bus.DIR_VALIDA !== exp_val) begin
            errors++;
            $display("FAIL ciclo t=%0t: DIR_MEM=%h DIR_VALIDA=%b, required %h %b",
                     $time, bus.DIR_MEM, bus.DIR_VALIDA, exp_mem, exp_val);
        end
    end

    // ---------------- helpers ----------------
    task automatic escribir(input logic [3:0] p, input logic [7:0] d);
        @(negedge clk);
        bus.RD = 1'b0; bus.POSICION = p; bus.DIR_DATO = d;
        @(negedge clk);
        bus.RD = 1'b1;
    endtask

    task automatic explorar(input int fila, input int col, input int lin);
        bus.Qv = 10'(fila * 16 + lin);
        bus.Qh = 7'(col);
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Checks a literal against both the DUT and the model.
    task automatic fijo(input string nombre, input logic [11:0] req_mem, input logic req_val);
        checks++;
        if (bus.DIR_MEM !== req_mem || bus.DIR_VALIDA !== req_val) begin
            errors++;
            $display("FAIL %s: DIR_MEM=%h DIR_VALIDA=%b, required %h %b",
                     nombre, bus.DIR_MEM, bus.DIR_VALIDA, req_mem, req_val);
        end
        checks++;
        if (exp_mem !== req_mem) begin
            errors++;
            $display("FAIL %s_modelo: model=%h, required %h", nombre, exp_mem, req_mem);
        end
    endtask

    task automatic chk_int(input string nombre, input int actual, input int requerido);
        checks++;
        if (actual != requerido) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nombre, actual, requerido);
        end
    endtask

    task automatic contar_validos(input int n, output int cuenta);
        cuenta = 0;
        repeat (n) begin
            @(negedge clk);
            #1;
            if (bus.DIR_VALIDA === 1'b1) cuenta++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int f, fila, col;

        bus.RD = 1'b1; bus.POSICION = 4'd0; bus.DIR_DATO = 8'h00;
        bus.EDIT_CAMPO = 4'd0; bus.Qh = 7'd0; bus.Qv = 10'd0;
        #1 rst = 1'b1;

        // A write held during reset must not survive.
        bus.RD = 1'b0; bus.POSICION = 4'd1; bus.DIR_DATO = 8'h11;
        repeat (3) @(negedge clk);
        #1 fijo("reset_estado", 12'h000, 1'b0);
        bus.RD = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        explorar(13, 10, 5);
        fijo("sin_escrituras_blanco", 12'h000, 1'b0);

        // Write presented across reset release lands on the first edge.
        @(negedge clk);
        #2 rst = 1'b1;
        bus.RD = 1'b0; bus.POSICION = 4'd1; bus.DIR_DATO = 8'h23;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        bus.RD = 1'b1;
        explorar(13, 10, 5);
        fijo("campo1_decenas", 12'h0E5, 1'b1);
        explorar(13, 11, 5);
        fijo("campo1_unidades", 12'h185, 1'b1);

        // Field 9 with a non-BCD units digit.
        escribir(4'd9, 8'h7A);
        explorar(15, 52, 5);
        fijo("campo9_siete", 12'h165, 1'b1);
        explorar(15, 53, 5);
        fijo("campo9_no_bcd", 12'h000, 1'b0);

        // Out-of-range positions are ignored.
        escribir(4'd0, 8'h55);
        escribir(4'd12, 8'h55);
        explorar(13, 10, 5);
        fijo("pos_invalida_c1", 12'h0E5, 1'b1);
        explorar(15, 52, 5);
        fijo("pos_invalida_c9", 12'h165, 1'b1);

        // Write and display of the same field in one cycle.
        explorar(13, 10, 5);
        bus.RD = 1'b0; bus.POSICION = 4'd1; bus.DIR_DATO = 8'h45;
        @(negedge clk);
        #1 fijo("colision_previo", 12'h0E5, 1'b1);
        bus.RD = 1'b1;
        @(negedge clk);
        #1 fijo("colision_nuevo", 12'h0F5, 1'b1);

        // Blink on the field being edited only.
        bus.EDIT_CAMPO = 4'd4;
        escribir(4'd4, 8'h59);
        escribir(4'd5, 8'h31);
        explorar(13, 73, 5);
        contar_validos(32, n);
        chk_int("parpadeo_campo4", n, 16);
        explorar(13, 76, 5);
        contar_validos(16, n);
        chk_int("campo5_fijo", n, 16);
        bus.EDIT_CAMPO = 4'd0;
        explorar(13, 73, 5);
        contar_validos(16, n);
        chk_int("edit0_sin_parpadeo", n, 16);
        bus.EDIT_CAMPO = 4'd13;
        explorar(13, 73, 5);
        contar_validos(16, n);
        chk_int("edit13_sin_parpadeo", n, 16);

        // Reset in the middle of a scan.
        bus.EDIT_CAMPO = 4'd0;
        escribir(4'd2, 8'h47);
        explorar(13, 13, 5);
        fijo("campo2_escrito", 12'h0F5, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 fijo("reset_inmediato", 12'h000, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        explorar(13, 13, 5);
        fijo("campo2_tras_reset", 12'h000, 1'b0);
        explorar(13, 10, 5);
        fijo("campo1_tras_reset", 12'h000, 1'b0);

        // Randomized writes, edit selects and beam positions.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.RD       = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            bus.POSICION = 4'($urandom_range(0, 15));
            bus.DIR_DATO = {4'(($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9)),
                            4'(($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9))};
            if ($urandom_range(0, 63) == 0) bus.EDIT_CAMPO = 4'($urandom_range(0, 12));
            if ($urandom_range(0, 3) != 0) begin
                f    = int'($urandom_range(1, 9));
                fila = FILA_M[f];
                col  = COL_M[f] + int'($urandom_range(0, 2));
            end else begin
                fila = int'($urandom_range(0, 63));
                col  = int'($urandom_range(0, 127));
            end
            bus.Qv = {6'(fila), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
            bus.Qh = 7'(col);
            if (c == 1500) #2 rst = 1'b1;
            if (c == 1503) #2 rst = 1'b0;
        end

        repeat (3) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gestor_digitos_vga.md
GESTOR_DIGITOS_VGA -- requirements
Module: gestor_digitos_vga

Interface
REQ-001 Parameter N_CAMPOS, default 9, number of two-digit BCD fields held (1..15).
REQ-002 Parameter ANCHO_PARPADEO, default 24, width of the free-running blink counter.
REQ-003 Port reloj  input  1  single clock; all state changes on its rising edge.
REQ-004 Port resetM  input  1  reset, asynchronous, active-high.
REQ-005 Port RD  input  1  active-low write strobe; DIR_DATO is captured while RD=0.
REQ-006 Port DIR_DATO  input  8  packed BCD pair: [7:4] tens, [3:0] units.
REQ-007 Port POSICION  input  4  target field index, 1..N_CAMPOS.
REQ-008 Port EDIT_CAMPO  input  4  field currently being edited; 0 means none.
REQ-009 Port Qh  input  7  current character column.
REQ-010 Port Qv  input  10  current pixel row; [9:4] is the character row, [2:0] is the glyph line.
REQ-011 Port DIR_MEM  output  12  character ROM address: {glyph code[7:0], 1'b0, Qv[2:0]}.
REQ-012 Port DIR_VALIDA  output  1  high when DIR_MEM addresses a digit glyph (not blank).

Function
REQ-013 Each field SHALL hold a 4-bit tens register and a 4-bit units register.
REQ-014 Write: on a rising edge with RD=0 and 1<=POSICION<=N_CAMPOS, the SHALL load DIR_DATO[7:4] into the tens register and DIR_DATO[3:0] into the units register of field POSICION.
REQ-015 Writes with POSICION=0 or POSICION>N_CAMPOS SHALL be ignored; no register changes.
REQ-016 Non-BCD nibbles (A-F) SHALL be stored unchanged and displayed as blank (code 8'h00).
REQ-017 Digit-to-code mapping SHALL be: 0->0D, 1->19, 2->0E, 3->18, 4->0F, 5->17, 6->10, 7->16, 8->11, 9->15.
REQ-018 Field layout (row, tens column; units column = tens column + 1) SHALL be: 1:(13,10) 2:(13,13) 3:(13,16) 4:(13,73) 5:(13,76) 6:(13,79) 7:(15,37) 8:(15,43) 9:(15,52).
REQ-019 Pipeline stage 1 SHALL register Qv[9:4], Qh and Qv[2:0].
REQ-020 Stage 2 SHALL decode the registered position and register DIR_MEM and DIR_VALIDA.
REQ-021 Latency from Qh/Qv to DIR_MEM SHALL be exactly 2 cycles.
REQ-022 A position matching no field digit SHALL produce DIR_MEM=12'h000 and DIR_VALIDA=0.
REQ-023 The blink counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-024 While the blink counter MSB=1, digits of field EDIT_CAMPO SHALL output DIR_MEM=12'h000 and DIR_VALIDA=0. Other fields SHALL be unaffected.
REQ-025 If a write and a display of the same field occur in the same cycle, stage 2 SHALL show the pre-write value; the new value SHALL appear from the following cycle.
REQ-026 EDIT_CAMPO=0 or EDIT_CAMPO>N_CAMPOS SHALL disable blanking.

Reset
REQ-027 While resetM=1, all digit registers SHALL be 4'hF (blank), the blink counter 0, both pipeline stages 0, DIR_MEM=12'h000 and DIR_VALIDA=0.
REQ-028 Reset asserted during a write SHALL win; no partial update SHALL survive.
REQ-029 The first write SHALL be accepted on the first rising edge after resetM deasserts.

Structure
REQ-030 A shared package SHALL hold the ten digit glyph codes, the blank code 8'h00, and the per-field row/column layout table. It is indexed by field and sized for 15 entries.
REQ-031 A combinational sub-module bcd_a_rom SHALL map a 4-bit nibble to an 8-bit glyph code. It is instantiated once, on the selected nibble in stage 2.

Verification
REQ-032 Reset, then scan row 13 col 10, no writes -> DIR_MEM=000 and DIR_VALIDA=0 (blank digits).
REQ-033 Write RD=0, POSICION=1, DIR_DATO=8'h23; drive Qv=13*16+5, Qh=10 -> two cycles later DIR_MEM=12'h0E5. Then Qh=11 -> DIR_MEM=12'h185.
REQ-034 Write POSICION=9, DIR_DATO=8'h7A; scan row 15 col 52 -> DIR_MEM=16x (SIETE). Scan col 53 -> DIR_MEM=000, DIR_VALIDA=0.
REQ-035 Write POSICION=0 and POSICION=12 with 8'h55 -> no field changes; all fields still read their previous values.
REQ-036 Set ANCHO_PARPADEO=4, EDIT_CAMPO=4, field 4 holds 8'h59 -> row 13 col 73 alternates 8 cycles 17x / 8 cycles 000. Field 5 stays steady.
REQ-037 Assert resetM mid-scan after writing field 2 -> DIR_MEM=000 in the same cycle; after release, field 2 reads blank.
